data_memory_ls: RTL and testbench
=================================

Name: data_memory_ls

Overview:
- Parametrised, byte-addressable, little-endian data memory for the MEM stage.
- Supports the RV32I load/store sizes (byte, half, word) selected by funct3, with sign or zero extension on loads.
- Read path is registered: load data returns one cycle after the request, qualified by a valid strobe.
- Adds a post-reset clearing sequencer plus misalignment, range and illegal-op fault reporting.

Parameters:
- DEPTH_BYTES, 1024, memory size in bytes; power of two, multiple of 4, ≥ 16.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset (INIT phase); 0 = skip INIT and start in READY with contents undefined.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  32  byte address of the access.
- writeData  in  32  store data; low bytes used for SB/SH.
- memRead  in  1  load request this cycle.
- memWrite  in  1  store request this cycle.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- memData  out  32  formatted load result, registered.
- memValid  out  1  one-cycle pulse: load response on memData.
- busy  out  1  high during INIT; requests are ignored.
- misaligned  out  1  one-cycle pulse: previous accepted access was misaligned.
- outOfRange  out  1  one-cycle pulse: previous accepted access exceeded the array.
- illegalOp  out  1  one-cycle pulse: previous accepted access had an unsupported funct3.

Behaviour:
- Reset (reset_n low, asynchronous):
  - memData=0, memValid=0, misaligned=0, outOfRange=0, illegalOp=0.
  - busy=CLEAR_ON_RESET; FSM enters INIT (or READY if CLEAR_ON_RESET=0); clear counter=0.
  - Reset asserted mid-operation drops any in-flight response and restarts INIT from word 0.
- FSM INIT:
  - Each cycle writes 32'h0 to word index cnt, then cnt++.
  - After word DEPTH_BYTES/4-1 is written, the next cycle is READY and busy falls.
  - INIT lasts exactly DEPTH_BYTES/4 cycles.
  - memRead/memWrite are ignored; no outputs pulse.
- FSM READY: a request is accepted on a rising edge with memRead or memWrite high.
  - Both high: treated as a store only; no load response.
- Address checks, with size = 1/2/4 bytes:
  - misaligned: half-word with address[0]=1, or word with address[1:0]≠0.
  - outOfRange: address + size > DEPTH_BYTES, compared in 33-bit arithmetic so that wrap-around never aliases.
  - illegalOp:
    - loads: funct3 ∈ {011,110,111};
    - stores: funct3 ∉ {000,001,010}.
  - Fault priority for the memory effect: any flag set means the access has no effect on the array. All applicable flags pulse together.
- Store:
  - Bytes written at the accepting edge: byte k of writeData goes to address+k, for k < size.
  - Other bytes are untouched.
  - No memValid pulse; fault flags pulse in the following cycle.
- Load:
  - Bytes are read at the accepting edge and formatted:
    - B/H sign-extend from bit 7/15;
    - BU/HU zero-extend;
    - W unchanged.
  - The result appears on memData in the following cycle with memValid=1 for one cycle.
  - A faulting load still pulses memValid, with memData=0 and the flag(s) set.
- memData holds its last value when memValid=0.
- Fault flags are 0 in any cycle not following an accepted access.
- Back-to-back:
  - A load one cycle after a store to the same address returns the new data.
  - Loads may issue every cycle: full throughput, latency 1.
- Byte order is little-endian: word at A = {mem[A+3], mem[A+2], mem[A+1], mem[A]}.

Test Plan:
- Reset, then hold idle with DEPTH_BYTES=64 → busy high exactly 16 cycles. Then LW at 0, 4, …, 60 → memData=0 and memValid=1 one cycle after each request.
- SW 0xDEADBEEF @0x20, then LW, LH, LHU, LB, LBU @0x20 → 0xDEADBEEF, 0xFFFFBEEF, 0x0000BEEF, 0xFFFFFFEF, 0x000000EF.
- SB 0x11 @0x21 over 0xDEADBEEF, then LW @0x20 → 0xDEAD11EF. SH 0x7F80 @0x22, then LW → 0x7F8011EF.
- LW @0x22 and SH @0x23 → misaligned pulses one cycle later; memory is unchanged, and the load returns memData=0 with memValid=1. LW @DEPTH_BYTES-2 → outOfRange=1. Load funct3=011 → illegalOp=1.
- memRead and memWrite both high with SW 0x12345678 @0x10 → no memValid pulse; a following LW @0x10 returns 0x12345678.
- reset_n pulsed low during INIT and on the cycle after an LW request → the response is suppressed (memValid stays 0) and INIT restarts for the full 16 cycles.

Source files
------------

// File: rtl/data_memory_ls.sv
// data_memory_ls
// Byte-addressable, little-endian data memory for the MEM stage of an RV32I
// pipeline. Supports LB/LH/LW/LBU/LHU and SB/SH/SW via funct3. The read path
// is registered: load data appears one cycle after the request, qualified by
// memValid. After reset an optional clearing sequencer zeroes every word while
// busy is high. Misaligned, out-of-range and illegal-funct3 accesses leave the
// array untouched and pulse the matching fault flag(s) in the next cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   address    byte address of the access
//   writeData  store data (low bytes used for SB/SH)
//   memRead    load request
//   memWrite   store request (wins when both are high)
//   funct3     000 B, 001 H, 010 W, 100 BU, 101 HU
//   memData    formatted load result, holds when memValid is low
//   memValid   one-cycle load response strobe
//   busy       high while the array is being cleared; requests are ignored
//   misaligned one-cycle pulse after a misaligned accepted access
//   outOfRange one-cycle pulse after an accepted access past the array end
//   illegalOp  one-cycle pulse after an accepted access with bad funct3
module data_memory_ls #(
  parameter int DEPTH_BYTES    = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  output logic [31:0] memData,
  output logic        memValid,
  output logic        busy,
  output logic        misaligned,
  output logic        outOfRange,
  output logic        illegalOp
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int CW    = $clog2(WORDS);

  typedef enum logic {INIT, READY} state_t;

  state_t          state;
  logic [CW-1:0]   clearCnt;
  logic [7:0]      mem [DEPTH_BYTES];

  logic            accept;
  logic            isStore;
  logic            isLoad;
  logic [2:0]      accessSize;
  logic            misalignedNow;
  logic            outOfRangeNow;
  logic            illegalNow;
  logic            fault;
  logic [AW-1:0]   baseIdx;
  logic [31:0]     loadWord;
  logic [31:0]     formatted;

  assign busy    = (state == INIT);
  assign accept  = (state == READY) && (memRead || memWrite);
  assign isStore = memWrite;
  assign isLoad  = memRead && !memWrite;
  assign baseIdx = address[AW-1:0];

  // Access size comes from funct3[1:0]; the unsupported 11 encoding is sized
  // as a word so its alignment/range checks stay well defined.
  always_comb begin
    accessSize = 3'd4;
    case (funct3[1:0])
      2'b00:   accessSize = 3'd1;
      2'b01:   accessSize = 3'd2;
      default: accessSize = 3'd4;
    endcase
  end

  // Fault detection. The range check is done with a 33-bit sum so an address
  // near 2^32 cannot wrap around and look like a small in-range address.
  always_comb begin
    misalignedNow = ((accessSize == 3'd2) && address[0]) ||
                    ((accessSize == 3'd4) && (address[1:0] != 2'b00));
    outOfRangeNow = ({1'b0, address} + 33'(accessSize)) > 33'(DEPTH_BYTES);
    if (isStore)
      illegalNow = !(funct3 inside {3'b000, 3'b001, 3'b010});
    else
      illegalNow = funct3 inside {3'b011, 3'b110, 3'b111};
    fault = misalignedNow || outOfRangeNow || illegalNow;
  end

  // Little-endian gather of the four bytes starting at the access address.
  // Indices wrap inside the array; wrapped lanes only matter for faulting
  // accesses, whose result is discarded.
  assign loadWord = {mem[baseIdx + AW'(3)], mem[baseIdx + AW'(2)],
                     mem[baseIdx + AW'(1)], mem[baseIdx]};

  // Sign or zero extension of the loaded value according to funct3.
  always_comb begin
    formatted = loadWord;
    case (funct3)
      3'b000:  formatted = {{24{loadWord[7]}}, loadWord[7:0]};
      3'b001:  formatted = {{16{loadWord[15]}}, loadWord[15:0]};
      3'b100:  formatted = {24'h0, loadWord[7:0]};
      3'b101:  formatted = {16'h0, loadWord[15:0]};
      default: formatted = loadWord;
    endcase
  end

  // Array writes: one whole word per cycle while clearing, otherwise the low
  // accessSize bytes of writeData for a fault-free store. The array itself is
  // never reset; clearing is done by the sequencer.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[{clearCnt, 2'd0}] <= 8'h00;
      mem[{clearCnt, 2'd1}] <= 8'h00;
      mem[{clearCnt, 2'd2}] <= 8'h00;
      mem[{clearCnt, 2'd3}] <= 8'h00;
    end else if (accept && isStore && !fault) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < accessSize)
          mem[baseIdx + AW'(k)] <= writeData[8*k +: 8];
      end
    end
  end

  // Control FSM and registered outputs. Reset drops any in-flight response
  // and restarts clearing from word 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR_ON_RESET ? INIT : READY;
      clearCnt   <= '0;
      memData    <= 32'h0;
      memValid   <= 1'b0;
      misaligned <= 1'b0;
      outOfRange <= 1'b0;
      illegalOp  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          memValid   <= 1'b0;
          misaligned <= 1'b0;
          outOfRange <= 1'b0;
          illegalOp  <= 1'b0;
          clearCnt   <= clearCnt + 1'b1;
          if (clearCnt == CW'(WORDS - 1))
            state <= READY;
        end
        READY: begin
          memValid   <= accept && isLoad;
          misaligned <= accept && misalignedNow;
          outOfRange <= accept && outOfRangeNow;
          illegalOp  <= accept && illegalNow;
          if (accept && isLoad)
            memData <= fault ? 32'h0 : formatted;
        end
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ls.sv
// tb_data_memory_ls
// Self-checking bench for data_memory_ls with a 64-byte array. A byte-array
// reference model derives the expected response of every request from the
// load/store rules directly; directed steps cover the clearing sequence,
// formatting, partial stores, faults and reset, followed by random traffic.
module tb_data_memory_ls;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] memData;
  logic        memValid;
  logic        busy;
  logic        misaligned;
  logic        outOfRange;
  logic        illegalOp;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [7:0]  model [DEPTH];
  logic [31:0] expData = '0;

  data_memory_ls #(.DEPTH_BYTES(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .writeData  (writeData),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .memData    (memData),
    .memValid   (memValid),
    .busy       (busy),
    .misaligned (misaligned),
    .outOfRange (outOfRange),
    .illegalOp  (illegalOp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expValid, input logic expMis,
                             input logic expOor, input logic expIll);
    check({tag, ".memValid"}, 32'(memValid), 32'(expValid));
    check({tag, ".memData"}, memData, expData);
    check({tag, ".misaligned"}, 32'(misaligned), 32'(expMis));
    check({tag, ".outOfRange"}, 32'(outOfRange), 32'(expOor));
    check({tag, ".illegalOp"}, 32'(illegalOp), 32'(expIll));
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    expData = '0;
  endtask

  // Drives one request at a negative edge, lets the DUT take it on the next
  // rising edge and checks the response at the following negative edge. The
  // inputs are left driven so consecutive calls issue back-to-back requests.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata);
    int     size;
    logic   accepted, isLoad, isStore, expMis, expOor, expIll;
    longint value;
    memRead   = rd;
    memWrite  = wr;
    funct3    = f3;
    address   = addr;
    writeData = wdata;
    size      = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
    accepted  = rd || wr;
    isStore   = wr;
    isLoad    = rd && !wr;
    expMis    = accepted && ((addr % size) != 0);
    expOor    = accepted && ((longint'(addr) + size) > DEPTH);
    expIll    = accepted && (isStore ? !(f3 inside {3'b000, 3'b001, 3'b010})
                                     : (f3 inside {3'b011, 3'b110, 3'b111}));
    if (isLoad) begin
      if (expMis || expOor || expIll) begin
        expData = 32'h0;
      end else begin
        value = 0;
        for (int k = 0; k < size; k++)
          value = value + (longint'(model[int'(addr) + k]) << (8 * k));
        if (f3 == 3'b000 && value >= 128)   value = value - 256;
        if (f3 == 3'b001 && value >= 32768) value = value - 65536;
        expData = value[31:0];
      end
    end
    if (isStore && !(expMis || expOor || expIll)) begin
      for (int k = 0; k < size; k++)
        model[int'(addr) + k] = wdata[8*k +: 8];
    end
    @(negedge clk);
    checkOutput(tag, isLoad, expMis, expOor, expIll);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  // Releases reset at a negative edge and counts the cycles busy stays high.
  task automatic releaseAndWaitInit(input string tag);
    int cycles;
    memRead  = 1'b0;
    memWrite = 1'b0;
    reset_n  = 1'b1;
    cycles   = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
      check({tag, ".initValid"}, 32'(memValid), 32'h0);
    end
    check({tag, ".initCycles"}, 32'(cycles), 32'(DEPTH / 4));
    clearModel();
  endtask

  task automatic resetDut(input string tag);
    memRead  = 1'b0;
    memWrite = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check({tag, ".rstData"}, memData, 32'h0);
    check({tag, ".rstValid"}, 32'(memValid), 32'h0);
    check({tag, ".rstFlags"}, {29'h0, misaligned, outOfRange, illegalOp}, 32'h0);
    check({tag, ".rstBusy"}, 32'(busy), 32'h1);
    @(negedge clk);
    releaseAndWaitInit(tag);
  endtask

  initial begin
    logic [2:0]  legalF3 [5];
    logic [2:0]  f3;
    logic [31:0] addr;
    int          op, size;
    legalF3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    resetDut("reset");

    for (int a = 0; a < DEPTH; a += 4)
      applyStimulus("lwCleared", 1'b1, 1'b0, 3'b010, 32'(a), 32'h0);

    applyStimulus("sw20", 1'b0, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
    applyStimulus("lw20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    applyStimulus("lh20", 1'b1, 1'b0, 3'b001, 32'h20, 32'h0);
    applyStimulus("lhu20", 1'b1, 1'b0, 3'b101, 32'h20, 32'h0);
    applyStimulus("lb20", 1'b1, 1'b0, 3'b000, 32'h20, 32'h0);
    applyStimulus("lbu20", 1'b1, 1'b0, 3'b100, 32'h20, 32'h0);
    applyStimulus("sb21", 1'b0, 1'b1, 3'b000, 32'h21, 32'h00000011);
    applyStimulus("lwAfterSb", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    applyStimulus("sh22", 1'b0, 1'b1, 3'b001, 32'h22, 32'h00007F80);
    applyStimulus("lwAfterSh", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    check("directWord", expData, 32'h7F8011EF);

    applyStimulus("lwMisaligned", 1'b1, 1'b0, 3'b010, 32'h22, 32'h0);
    applyStimulus("shMisaligned", 1'b0, 1'b1, 3'b001, 32'h23, 32'h0000AAAA);
    applyStimulus("lwUnchanged", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    applyStimulus("lwOutOfRange", 1'b1, 1'b0, 3'b010, 32'(DEPTH - 2), 32'h0);
    applyStimulus("lwWrapAddr", 1'b1, 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0);
    applyStimulus("loadIllegal", 1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
    applyStimulus("storeIllegal", 1'b0, 1'b1, 3'b100, 32'h8, 32'hFFFFFFFF);
    applyStimulus("bothHighSw", 1'b1, 1'b1, 3'b010, 32'h10, 32'h12345678);
    applyStimulus("lwAfterBoth", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    idle("idleHold");
    idle("idleHold2");

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 9) == 0) begin
        f3   = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b110 + 3'($urandom_range(0, 1));
        if (op >= 6) f3 = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b111;
        addr = 32'($urandom_range(0, DEPTH / 8 - 1) * 8);
      end else begin
        f3   = legalF3[$urandom_range(0, 4)];
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        addr = 32'($urandom_range(0, DEPTH + 3));
        if ($urandom_range(0, 9) < 7) addr = addr - (addr % size);
        if ($urandom_range(0, 19) == 0) addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      end
      case (op)
        0:       applyStimulus("rndIdle", 1'b0, 1'b0, f3, addr, $urandom);
        1:       applyStimulus("rndBoth", 1'b1, 1'b1, f3, addr, $urandom);
        2, 3, 4, 5: applyStimulus("rndLoad", 1'b1, 1'b0, f3, addr, $urandom);
        default: applyStimulus("rndStore", 1'b0, 1'b1, f3, addr, $urandom);
      endcase
    end
    idle("rndEnd");

    // Reset arriving right after a load has been accepted must drop its response.
    applyStimulus("preResetSw", 1'b0, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D);
    memRead  = 1'b1;
    memWrite = 1'b0;
    funct3   = 3'b010;
    address  = 32'h10;
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    memRead  = 1'b0;
    @(negedge clk);
    check("lwResetValid", 32'(memValid), 32'h0);
    check("lwResetData", memData, 32'h0);
    releaseAndWaitInit("lwReset");
    applyStimulus("lwAfterClear", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);

    // Reset pulsed in the middle of clearing restarts it from word 0.
    resetDut("initReset");
    applyStimulus("fillSw", 1'b0, 1'b1, 3'b010, 32'h3C, 32'h89ABCDEF);
    idle("fillIdle");
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    memWrite = 1'b1;
    funct3   = 3'b010;
    address  = 32'h0;
    writeData = 32'hFFFFFFFF;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midInitBusy", 32'(busy), 32'h1);
    @(negedge clk);
    releaseAndWaitInit("midInit");
    applyStimulus("lwCleared0", 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    applyStimulus("lwCleared3C", 1'b1, 1'b0, 3'b010, 32'h3C, 32'h0);
    idle("finalIdle");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
